mem_stage_lsu: RTL

Memory-stage load/store unit: the consumer of the EX/MEM pipeline register outputs. It issues data-memory bus transactions with a req/ack handshake and stalls the pipeline until ack. It aligns and extends load data, forms store strobes, and registers the MEM/WB result. Non-memory instructions pass through with one cycle of latency and no stall.

---
 rtl/mem_stage_lsu.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit with req/ack data bus, load extension and MEM/WB register
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        is_flush,
    input  logic [31:0] PC_in,
    input  logic [4:0]  rd_in,
    input  logic        RegWrite_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [2:0]  DMType_in,
    input  logic [2:0]  WDSel_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] rs2_in,
    output logic        stall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_wstrb,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_RegWrite,
    output logic [2:0]  wb_WDSel,
    output logic [31:0] wb_PC,
    output logic [31:0] wb_data,
    output logic        ale,
    output logic        bus_err,
    output logic [31:0] badv
);
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [2:0]    dmtype_q, dmtype_d;
    logic          flushed_q, flushed_d;
    logic          dm_req_q, dm_req_d;
    logic          dm_we_q, dm_we_d;
    logic [31:0]   dm_addr_q, dm_addr_d;
    logic [3:0]    dm_wstrb_q, dm_wstrb_d;
    logic [31:0]   dm_wdata_q, dm_wdata_d;
    logic          wb_valid_q, wb_valid_d;
    logic [4:0]    wb_rd_q, wb_rd_d;
    logic          wb_regwrite_q, wb_regwrite_d;
    logic [2:0]    wb_wdsel_q, wb_wdsel_d;
    logic [31:0]   wb_pc_q, wb_pc_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic          ale_q, ale_d;
    logic          bus_err_q, bus_err_d;
    logic [31:0]   badv_q, badv_d;

    logic          mem_op, aligned, timed_out;
    logic [3:0]    st_strb;
    logic [31:0]   st_data, ld_data;
    logic [15:0]   lane;

    assign mem_op    = in_valid & !is_flush & (MemRead_in | MemWrite_in);
    assign aligned   = (DMType_in == 3'd0) ? (alu_result_in[1:0] == 2'b00) :
                       (DMType_in <= 3'd2) ? !alu_result_in[0] : (DMType_in <= 3'd4);
    assign st_strb   = (DMType_in == 3'd0) ? 4'b1111 :
                       (DMType_in <= 3'd2) ? (alu_result_in[1] ? 4'b1100 : 4'b0011) :
                       4'b0001 << alu_result_in[1:0];
    assign st_data   = (DMType_in == 3'd0) ? rs2_in :
                       (DMType_in <= 3'd2) ? {2{rs2_in[15:0]}} : {4{rs2_in[7:0]}};
    // Halves are always 2-byte aligned, so shifting by the byte offset lands either size in the low lane.
    assign lane      = 16'(dm_rdata >> {addr_q[1:0], 3'b000});
    assign ld_data   = (dmtype_q == 3'd1) ? {{16{lane[15]}}, lane} :
                       (dmtype_q == 3'd2) ? {16'b0, lane} :
                       (dmtype_q == 3'd3) ? {{24{lane[7]}}, lane[7:0]} :
                       (dmtype_q == 3'd4) ? {24'b0, lane[7:0]} : dm_rdata;
    assign timed_out = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));
    assign stall     = (state_q == IDLE) ? (mem_op & aligned) : !dm_ack;

    assign dm_req      = dm_req_q;
    assign dm_we       = dm_we_q;
    assign dm_addr     = dm_addr_q;
    assign dm_wstrb    = dm_wstrb_q;
    assign dm_wdata    = dm_wdata_q;
    assign wb_valid    = wb_valid_q;
    assign wb_rd       = wb_rd_q;
    assign wb_RegWrite = wb_regwrite_q;
    assign wb_WDSel    = wb_wdsel_q;
    assign wb_PC       = wb_pc_q;
    assign wb_data     = wb_data_q;
    assign ale         = ale_q;
    assign bus_err     = bus_err_q;
    assign badv        = badv_q;

    // Next state: issue from IDLE, then finish on ack or abort on timeout (ack wins a tie).
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        dmtype_d      = dmtype_q;
        flushed_d     = flushed_q;
        dm_req_d      = dm_req_q;
        dm_we_d       = dm_we_q;
        dm_addr_d     = dm_addr_q;
        dm_wstrb_d    = dm_wstrb_q;
        dm_wdata_d    = dm_wdata_q;
        wb_valid_d    = 1'b0;
        wb_rd_d       = wb_rd_q;
        wb_regwrite_d = wb_regwrite_q;
        wb_wdsel_d    = wb_wdsel_q;
        wb_pc_d       = wb_pc_q;
        wb_data_d     = wb_data_q;
        ale_d         = 1'b0;
        bus_err_d     = 1'b0;
        badv_d        = badv_q;
        if (state_q == IDLE) begin
            wb_valid_d    = in_valid & !is_flush;
            wb_rd_d       = rd_in;
            wb_regwrite_d = RegWrite_in & !mem_op;
            wb_wdsel_d    = WDSel_in;
            wb_pc_d       = PC_in;
            wb_data_d     = alu_result_in;
            if (mem_op && aligned) begin
                state_d       = BUSY;
                cnt_d         = '0;
                addr_d        = alu_result_in;
                dmtype_d      = DMType_in;
                flushed_d     = 1'b0;
                dm_req_d      = 1'b1;
                dm_we_d       = MemWrite_in;
                dm_addr_d     = {alu_result_in[31:2], 2'b00};
                dm_wstrb_d    = MemWrite_in ? st_strb : 4'b0000;
                dm_wdata_d    = st_data;
                wb_valid_d    = 1'b0;
                wb_regwrite_d = RegWrite_in & !MemWrite_in;
            end else if (mem_op) begin
                ale_d  = 1'b1;
                badv_d = alu_result_in;
            end
        end else if (dm_ack) begin
            state_d    = IDLE;
            dm_req_d   = 1'b0;
            wb_valid_d = !(flushed_q | is_flush);
            wb_data_d  = dm_we_q ? addr_q : ld_data;
        end else if (timed_out) begin
            state_d       = IDLE;
            dm_req_d      = 1'b0;
            bus_err_d     = 1'b1;
            badv_d        = addr_q;
            wb_valid_d    = 1'b1;
            wb_regwrite_d = 1'b0;
            wb_data_d     = addr_q;
        end else begin
            cnt_d     = cnt_q + CW'(1);
            flushed_d = flushed_q | is_flush;
        end
    end

    // State and output registers, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            dmtype_q      <= '0;
            flushed_q     <= 1'b0;
            dm_req_q      <= 1'b0;
            dm_we_q       <= 1'b0;
            dm_addr_q     <= '0;
            dm_wstrb_q    <= '0;
            dm_wdata_q    <= '0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= '0;
            wb_regwrite_q <= 1'b0;
            wb_wdsel_q    <= '0;
            wb_pc_q       <= '0;
            wb_data_q     <= '0;
            ale_q         <= 1'b0;
            bus_err_q     <= 1'b0;
            badv_q        <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            dmtype_q      <= dmtype_d;
            flushed_q     <= flushed_d;
            dm_req_q      <= dm_req_d;
            dm_we_q       <= dm_we_d;
            dm_addr_q     <= dm_addr_d;
            dm_wstrb_q    <= dm_wstrb_d;
            dm_wdata_q    <= dm_wdata_d;
            wb_valid_q    <= wb_valid_d;
            wb_rd_q       <= wb_rd_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_wdsel_q    <= wb_wdsel_d;
            wb_pc_q       <= wb_pc_d;
            wb_data_q     <= wb_data_d;
            ale_q         <= ale_d;
            bus_err_q     <= bus_err_d;
            badv_q        <= badv_d;
        end
    end
endmodule
